int_to_fp_encoder: RTL and testbench



---
 rtl/int_to_fp_encoder.sv | 122 ++++++++++++
 tb/tb_int_to_fp_encoder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/int_to_fp_encoder.sv
// Signed 32-bit integer to FPU float encoder: 1-bit/cycle normaliser, round-to-nearest-even,
// valid/ready on both sides. Float word is {sign, exp[9:0] bias 511, mantissa[20:0]}.
module int_to_fp_encoder (
  input  logic        clock_100Khz,
  input  logic        reset,
  input  logic [31:0] int_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] data_out,
  output logic [3:0]  status_out,
  output logic        out_valid,
  input  logic        out_ready
);

  // Status codes 0 (overflow) and 1 (underflow) are unreachable from a 32-bit integer.
  localparam logic [3:0] StatusExact   = 4'd2;
  localparam logic [3:0] StatusInexact = 4'd3;
  localparam logic [9:0] ExpStart      = 10'd542;

  typedef enum logic [1:0] {StIdle, StNormalize, StRound, StHold} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic        r_sign;
  logic [31:0] r_mag;
  logic [9:0]  r_exp;
  logic [31:0] r_data;
  logic [3:0]  r_status;

  logic        w_accept;
  logic [31:0] w_abs;
  logic [20:0] w_mant;
  logic        w_guard;
  logic        w_sticky;
  logic        w_inc;
  logic        w_carry;
  logic [20:0] w_mant_rnd;
  logic [9:0]  w_exp_rnd;

  assign w_accept   = in_valid && in_ready;
  assign w_abs      = int_in[31] ? (~int_in + 32'd1) : int_in;
  assign w_mant     = r_mag[30:10];
  assign w_guard    = r_mag[9];
  assign w_sticky   = |r_mag[8:0];
  assign w_inc      = w_guard && (w_sticky || w_mant[0]);
  // An all-ones mantissa wraps to zero on increment; the carry bumps the exponent.
  assign w_carry    = w_inc && (&w_mant);
  assign w_mant_rnd = w_mant + {20'd0, w_inc};
  assign w_exp_rnd  = r_exp + {9'd0, w_carry};

  always_ff @(posedge clock_100Khz) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) w_state_next = StNormalize;
      end
      StNormalize: begin
        if (r_mag == 32'd0) begin
          w_state_next = StHold;
        end else if (r_mag[31]) begin
          w_state_next = StRound;
        end
      end
      StRound: w_state_next = StHold;
      StHold: begin
        if (out_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == StIdle) && !reset;
    out_valid = (r_state == StHold);
  end

  always_ff @(posedge clock_100Khz) begin
    if (reset) begin
      r_sign   <= 1'b0;
      r_mag    <= 32'd0;
      r_exp    <= 10'd0;
      r_data   <= 32'd0;
      r_status <= StatusExact;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_sign <= int_in[31];
            r_mag  <= w_abs;
            r_exp  <= ExpStart;
          end
        end
        StNormalize: begin
          if (r_mag == 32'd0) begin
            r_data   <= 32'd0;
            r_status <= StatusExact;
          end else if (!r_mag[31]) begin
            r_mag <= r_mag << 1;
            r_exp <= r_exp - 10'd1;
          end
        end
        StRound: begin
          r_data   <= {r_sign, w_exp_rnd, w_mant_rnd};
          r_status <= (w_guard || w_sticky) ? StatusInexact : StatusExact;
        end
        default: ;
      endcase
    end
  end

  assign data_out   = r_data;
  assign status_out = r_status;

endmodule

// File: tb/tb_int_to_fp_encoder.sv
// Scoreboard bench for int_to_fp_encoder: stimulus pushes model results, a negedge monitor
// checks latency, hold stability and the transferred result.
module tb_int_to_fp_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] int_in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_out;
  logic [3:0]  status_out;
  logic        out_valid;
  logic        out_ready;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  status;
    int          lat;
    int          e0;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;

  int_to_fp_encoder dut (
    .clock_100Khz(clk),
    .reset       (reset),
    .int_in      (int_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_out    (data_out),
    .status_out  (status_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference: value = 2^p * (1 + frac/2^p), mantissa = frac scaled to 21 bits, RNE on the rest.
  function automatic exp_t model(input logic [31:0] v);
    exp_t        r;
    longint      sv, mag, frac, q, rem, half;
    int          p, e, sh;
    logic [9:0]  e10;
    logic [20:0] q21;
    sv  = longint'($signed(v));
    mag = (sv < 0) ? -sv : sv;
    r.e0 = 0;
    if (mag == 0) begin
      r.data = 32'd0; r.status = 4'd2; r.lat = 1;
      return r;
    end
    p = 31;
    while (((mag >> p) & 1) == 0) p--;
    r.lat = (31 - p) + 2;
    e = 511 + p;
    frac = mag - (longint'(1) << p);
    rem = 0;
    if (p <= 21) begin
      q = frac << (21 - p);
    end else begin
      sh   = p - 21;
      q    = frac >> sh;
      rem  = frac & ((longint'(1) << sh) - 1);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q++;
      if (q == (longint'(1) << 21)) begin
        q = 0;
        e++;
      end
    end
    e10 = 10'(e);
    q21 = 21'(q);
    r.data   = {v[31], e10, q21};
    r.status = (rem != 0) ? 4'd3 : 4'd2;
    return r;
  endfunction

  // Monitor: all sampling on the falling edge.
  logic        mon_hold = 1'b0;
  logic        mon_post = 1'b0;
  logic [31:0] mon_data;
  logic [3:0]  mon_status;

  always @(negedge clk) begin
    if (reset) begin
      mon_hold = 1'b0;
      mon_post = 1'b0;
    end else if (out_valid) begin
      if (!mon_hold) begin
        mon_hold   = 1'b1;
        mon_data   = data_out;
        mon_status = status_out;
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_output: got data 0x%08h with empty scoreboard", data_out);
        end else begin
          check("latency", 32'(cyc - sb[0].e0), 32'(sb[0].lat));
        end
      end else begin
        check("hold_data_stable", data_out, mon_data);
        check("hold_status_stable", {28'd0, status_out}, {28'd0, mon_status});
      end
      check("in_ready_busy", {31'd0, in_ready}, 32'd0);
      if (out_ready) begin
        if (sb.size() != 0) begin
          check("data_out", data_out, sb[0].data);
          check("status_out", {28'd0, status_out}, {28'd0, sb[0].status});
          void'(sb.pop_front());
        end
        mon_hold = 1'b0;
        mon_post = 1'b1;
      end
    end else if (mon_post) begin
      check("in_ready_after_xfer", {31'd0, in_ready}, 32'd1);
      mon_post = 1'b0;
    end
  end

  // Stimulus changes inputs 1 time unit after the rising edge.
  task automatic issue(input logic [31:0] v, input int bp);
    exp_t e;
    int   n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      n_total++;
      $display("FAIL in_ready_timeout: got in_ready 0 expected 1 for operand 0x%08h", v);
      return;
    end
    e    = model(v);
    e.e0 = cyc + 1;
    sb.push_back(e);
    in_valid = 1'b1;
    int_in   = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    int_in   = $urandom;
    n = 0;
    while (!out_valid && n < 60) begin
      @(posedge clk); #1; n++;
    end
    if (!out_valid) begin
      n_total++;
      $display("FAIL out_valid_timeout: got out_valid 0 expected 1 for operand 0x%08h", v);
      sb.delete();
      return;
    end
    // Operands offered while busy must be ignored.
    repeat (bp) begin
      in_valid = 1'b1;
      int_in   = $urandom;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    int          sel;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    int_in    = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data_out", data_out, 32'd0);
    check("rst_status_out", {28'd0, status_out}, 32'd2);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    issue(32'd1, 0);
    issue(32'hFFFF_FFFF, 1);
    issue(32'd0, 0);
    issue(32'h8000_0000, 2);
    issue(32'h7FFF_FFFF, 0);
    issue(32'h4000_0100, 5);
    issue(32'h4000_0300, 0);
    issue(32'h0000_0005, 3);

    // Reset while normalising int_in = 1; nothing may come out of it.
    @(posedge clk); #1;
    in_valid = 1'b1;
    int_in   = 32'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_data_out", data_out, 32'd0);
    check("midrst_status_out", {28'd0, status_out}, 32'd2);
    check("midrst_in_ready_low", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    issue(32'd5, 0);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 3);
      unique case (sel)
        0: v = $urandom;
        1: v = 32'($urandom_range(0, 1000));
        2: v = ($urandom & 32'h3FFF_FE00) | 32'h4000_0100;
        default: v = 32'd1 << $urandom_range(0, 31);
      endcase
      if (sel != 0 && $urandom_range(0, 1) == 1) v = -v;
      issue(v, $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
